// File: rtl/sobol_pkg.sv
// Shared types, defaults and helpers for the single-dimension Sobol generator.
package sobol_pkg;

  localparam int INWD_DEF    = 8;
  localparam int LOGINWD_DEF = $clog2(INWD_DEF);

  typedef logic [INWD_DEF-1:0]    dir_vec_t;
  typedef logic [LOGINWD_DEF-1:0] dir_idx_t;

  // Dimension-1 (van der Corput) direction vector k: a single bit walking
  // down from the MSB, so the output is the bit-reversed Gray code of the count.
  function automatic logic [31:0] default_dir_vec(input int k, input int inwd = INWD_DEF);
    return 32'(1) << (inwd - 1 - k);
  endfunction

endpackage

// File: rtl/sobol_seq_gen_lsz_index.sv
// Least-significant-zero finder: prefix-OR of the inverted count, one-hot
// edge detect, binary encode. An all-ones count is reported through
// none_found rather than being confused with index 0.
module lsz_index #(
  parameter int INWD    = 8,
  parameter int LOGINWD = $clog2(INWD)
) (
  input  logic [INWD-1:0]    cnt,
  output logic [LOGINWD-1:0] idx,
  output logic               none_found
);

  logic [INWD-1:0] inv;
  logic [INWD-1:0] pre;
  logic [INWD-1:0] onehot;

  assign inv       = ~cnt;
  assign pre[0]    = inv[0];
  assign onehot[0] = pre[0];

  for (genvar i = 1; i < INWD; i++) begin : g_pre
    assign pre[i]    = pre[i-1] | inv[i];
    assign onehot[i] = pre[i] & ~pre[i-1];
  end

  assign none_found = ~pre[INWD-1];

  // OR-encode the single set bit of onehot into a binary index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < INWD; i++)
      if (onehot[i]) idx = idx | LOGINWD'(i);
  end

endmodule

// File: rtl/sobol_seq_gen.sv
// Single-dimension Sobol sequence generator. Each advance XORs the direction
// vector selected by the least-significant zero of the step counter into the
// state; the table is runtime-writable so other dimensions can be produced.
module sobol_seq_gen
  import sobol_pkg::*;
#(
  parameter int INWD    = INWD_DEF,
  parameter int LOGINWD = $clog2(INWD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic               dir_wr_en,
  input  logic [LOGINWD-1:0] dir_wr_addr,
  input  logic [INWD-1:0]    dir_wr_data,
  output logic [INWD-1:0]    seq_out,
  output logic               seq_valid,
  output logic               seq_wrap,
  output logic [LOGINWD-1:0] lsz_idx
);

  logic [INWD-1:0]    cnt;
  logic [INWD-1:0]    vtab [INWD];
  logic [INWD-1:0]    vdef [INWD];
  logic [LOGINWD-1:0] idx;
  logic               none_found;

  for (genvar k = 0; k < INWD; k++) begin : g_vdef
    assign vdef[k] = INWD'(default_dir_vec(k, INWD));
  end

  lsz_index #(.INWD(INWD), .LOGINWD(LOGINWD)) u_lsz (
    .cnt        (cnt),
    .idx        (idx),
    .none_found (none_found)
  );

  // Direction table: defaults on reset; out-of-range addresses are dropped.
  // Reads this cycle see the pre-write value, so a same-cycle advance uses the old vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < INWD; k++) vtab[k] <= vdef[k];
    end else if (dir_wr_en && (32'(dir_wr_addr) < INWD)) begin
      vtab[dir_wr_addr] <= dir_wr_data;
    end
  end

  // Counter/state/output registers; clear beats en, all-ones count wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      seq_out   <= '0;
      seq_valid <= 1'b0;
      seq_wrap  <= 1'b0;
      lsz_idx   <= '0;
    end else if (clear) begin
      cnt       <= '0;
      seq_out   <= '0;
      seq_valid <= 1'b0;
      seq_wrap  <= 1'b0;
      lsz_idx   <= '0;
    end else if (en) begin
      seq_valid <= 1'b1;
      if (none_found) begin
        cnt      <= '0;
        seq_out  <= '0;
        seq_wrap <= 1'b1;
        lsz_idx  <= '0;
      end else begin
        cnt      <= cnt + 1'b1;
        seq_out  <= seq_out ^ vtab[idx];
        seq_wrap <= 1'b0;
        lsz_idx  <= idx;
      end
    end else begin
      seq_valid <= 1'b0;
      seq_wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobol_seq_gen.sv
// Directed bench for sobol_seq_gen: an 8-bit instance for the main behaviour
// and a 6-bit instance where out-of-range table addresses are representable.
module tb_sobol_seq_gen;
  import sobol_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, en, wr_en;
  logic [2:0] wr_addr;
  dir_vec_t   wr_data;
  dir_vec_t   seq_out;
  logic       seq_valid, seq_wrap;
  logic [2:0] lsz_idx;

  logic       en6, wr_en6;
  logic [2:0] wr_addr6;
  logic [5:0] wr_data6;
  logic [5:0] seq_out6;
  logic       seq_valid6, seq_wrap6;
  logic [2:0] lsz_idx6;

  sobol_seq_gen #(.INWD(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en),
    .dir_wr_en(wr_en), .dir_wr_addr(wr_addr), .dir_wr_data(wr_data),
    .seq_out(seq_out), .seq_valid(seq_valid), .seq_wrap(seq_wrap), .lsz_idx(lsz_idx)
  );

  sobol_seq_gen #(.INWD(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .en(en6),
    .dir_wr_en(wr_en6), .dir_wr_addr(wr_addr6), .dir_wr_data(wr_data6),
    .seq_out(seq_out6), .seq_valid(seq_valid6), .seq_wrap(seq_wrap6), .lsz_idx(lsz_idx6)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected value after n advances with default vectors: bit-reversed Gray code of n.
  function automatic logic [7:0] model(input int n);
    logic [7:0] g, r;
    g = 8'(n ^ (n >> 1));
    for (int i = 0; i < 8; i++) r[7-i] = g[i];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    en6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic e, input logic c);
    en = e; clear = c;
    @(posedge clk); #1;
    en = 1'b0; clear = 1'b0; wr_en = 1'b0;
  endtask

  task automatic step6(input logic e);
    en6 = e;
    @(posedge clk); #1;
    en6 = 1'b0; wr_en6 = 1'b0;
  endtask

  logic [7:0] exp_out [4] = '{8'h80, 8'hC0, 8'h40, 8'h60};
  logic [2:0] exp_idx [4] = '{3'd0, 3'd1, 3'd0, 3'd2};
  logic [5:0] exp6    [4] = '{6'h20, 6'h30, 6'h10, 6'h18};
  bit         seen [256];
  int         nseen;

  initial begin
    // Reset state, observed while reset is held
    rst_n = 1'b0; clear = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    en6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0;
    #12;
    chk("rst_out",   32'(seq_out),   32'h0);
    chk("rst_valid", 32'(seq_valid), 32'h0);
    chk("rst_wrap",  32'(seq_wrap),  32'h0);
    chk("rst_lsz",   32'(lsz_idx),   32'h0);

    // Four advances from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("adv%0d_out", i),   32'(seq_out),   32'(exp_out[i]));
      chk($sformatf("adv%0d_lsz", i),   32'(lsz_idx),   32'(exp_idx[i]));
      chk($sformatf("adv%0d_valid", i), 32'(seq_valid), 32'h1);
    end

    // en pattern 1,0,0,1
    do_reset();
    step(1'b1, 1'b0);
    chk("idle_a_out", 32'(seq_out), 32'h80);
    step(1'b0, 1'b0);
    chk("idle_b_out",   32'(seq_out),   32'h80);
    chk("idle_b_valid", 32'(seq_valid), 32'h0);
    chk("idle_b_lsz",   32'(lsz_idx),   32'h0);
    step(1'b0, 1'b0);
    chk("idle_c_out",   32'(seq_out),   32'h80);
    chk("idle_c_valid", 32'(seq_valid), 32'h0);
    step(1'b1, 1'b0);
    chk("idle_d_out",   32'(seq_out),   32'hC0);
    chk("idle_d_valid", 32'(seq_valid), 32'h1);
    chk("idle_d_lsz",   32'(lsz_idx),   32'h1);

    // clear together with en after three advances
    do_reset();
    repeat (3) step(1'b1, 1'b0);
    chk("pre_clr_out", 32'(seq_out), 32'h40);
    step(1'b1, 1'b1);
    chk("clr_out",   32'(seq_out),   32'h0);
    chk("clr_valid", 32'(seq_valid), 32'h0);
    chk("clr_lsz",   32'(lsz_idx),   32'h0);
    step(1'b1, 1'b0);
    chk("post_clr_out", 32'(seq_out), 32'h80);

    // Table write in same cycle as advance uses old value; later advances use new one
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h01;
    step(1'b1, 1'b0);
    chk("wr_same_out", 32'(seq_out), 32'h80);
    step(1'b0, 1'b1);
    chk("wr_clr_out", 32'(seq_out), 32'h0);
    step(1'b1, 1'b0);
    chk("wr_new_out0", 32'(seq_out), 32'h01);
    step(1'b1, 1'b0);
    chk("wr_new_out1", 32'(seq_out), 32'h41);

    // Asynchronous reset mid-operation restores zero state and default vectors
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out",   32'(seq_out),   32'h0);
    chk("async_rst_valid", 32'(seq_valid), 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    #3;
    step(1'b1, 1'b0);
    chk("post_rst_out", 32'(seq_out), 32'h80);

    // Full period: every value once, wrap pulse on advance 256
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    seen[seq_out] = 1'b1;
    chk("per_start", 32'(seq_out), 32'h0);
    for (int n = 1; n <= 256; n++) begin
      step(1'b1, 1'b0);
      chk($sformatf("per%0d_out", n),   32'(seq_out),   32'(model(n % 256)));
      chk($sformatf("per%0d_wrap", n),  32'(seq_wrap),  32'(n == 256));
      chk($sformatf("per%0d_valid", n), 32'(seq_valid), 32'h1);
      if (n < 256) seen[seq_out] = 1'b1;
    end
    chk("per_wrap_lsz", 32'(lsz_idx), 32'h0);
    nseen = 0;
    foreach (seen[i]) if (seen[i]) nseen++;
    chk("per_coverage", 32'(nseen), 32'd256);
    step(1'b1, 1'b0);
    chk("after_wrap_out",  32'(seq_out),  32'h80);
    chk("after_wrap_wrap", 32'(seq_wrap), 32'h0);
    chk("after_wrap_lsz",  32'(lsz_idx),  32'h0);

    // Out-of-range table addresses (6-bit instance: 6 and 7 do not exist)
    do_reset();
    wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 6'h3F;
    step6(1'b0);
    wr_en6 = 1'b1; wr_addr6 = 3'd6; wr_data6 = 6'h2A;
    step6(1'b0);
    for (int i = 0; i < 4; i++) begin
      step6(1'b1);
      chk($sformatf("oor%0d_out", i), 32'(seq_out6), 32'(exp6[i]));
      chk($sformatf("oor%0d_lsz", i), 32'(lsz_idx6), 32'(exp_idx[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
